morse_signal_classifier: RTL and testbench

- Upstream stage of the sequence producer. Converts the raw Morse key line into the 3-bit Signals code stream that the producer consumes.
- Synchronises and debounces the key, then measures press and gap durations in time units.
- Emits dot/dash per press, EndSeq at each letter boundary, and Space at each word boundary.
- Each event is a one-cycle code on Signals, with a strobe; between events Signals rests at an idle code.

---
 rtl/morse_pkg.sv | 16 +
 rtl/key_debouncer.sv | 49 ++++
 rtl/morse_signal_classifier.sv | 102 ++++++++++
 tb/tb_morse_signal_classifier.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared Morse codes and classifier states; used by the classifier and the sequence producer.
package morse_pkg;

    localparam logic [2:0] SIG_DOT    = 3'b000;
    localparam logic [2:0] SIG_DASH   = 3'b001;
    localparam logic [2:0] SIG_SPACE  = 3'b010;
    localparam logic [2:0] SIG_ENDSEQ = 3'b011;
    localparam logic [2:0] SIG_NONE   = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } cls_state_t;

endpackage

// File: rtl/key_debouncer.sv
// Key synchroniser + debouncer with one-cycle press/release pulses; latency 2 + DEBOUNCE cycles.
// Backpressure: none, free-running.
module key_debouncer #(
    parameter int DEBOUNCE = 2
) (
    input  logic Clk,
    input  logic Resetbar,
    input  logic Key_raw,
    output logic Key_db,
    output logic Press_evt,
    output logic Release_evt
);

    localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    logic            sync_1;
    logic            sync_2;
    logic            db_q;
    logic [DB_W-1:0] stable_cnt;

    always_ff @(posedge Clk or negedge Resetbar) begin
        if (!Resetbar) begin
            sync_1     <= 1'b0;
            sync_2     <= 1'b0;
            Key_db     <= 1'b0;
            db_q       <= 1'b0;
            stable_cnt <= '0;
        end else begin
            sync_1 <= Key_raw;
            sync_2 <= sync_1;
            db_q   <= Key_db;
            // Any return to the current level restarts the stability count.
            if (sync_2 != Key_db) begin
                if (stable_cnt == DB_W'(DEBOUNCE - 1)) begin
                    Key_db     <= sync_2;
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + 1'b1;
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

    assign Press_evt   =  Key_db & ~db_q;
    assign Release_evt = ~Key_db &  db_q;

endmodule

// File: rtl/morse_signal_classifier.sv
// Classifies debounced key presses/gaps into dot, dash, end-of-letter and word-space codes.
// Latency: event code registered 1 cycle after its debounced edge or tick; backpressure: none.
module morse_signal_classifier
    import morse_pkg::*;
#(
    parameter int TICK_DIV         = 4,
    parameter int DEBOUNCE         = 2,
    parameter int DASH_UNITS       = 3,
    parameter int LETTER_GAP_UNITS = 3,
    parameter int WORD_GAP_UNITS   = 7,
    parameter int CNT_W            = 8
) (
    input  logic       Clk,
    input  logic       Resetbar,
    input  logic       Key,
    input  logic       Clear,
    output logic [2:0] Signals,
    output logic       Sig_Valid
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic             key_db;
    logic             press_evt;
    logic             release_evt;
    logic             tick;
    logic [PW-1:0]    pres;
    logic [CNT_W-1:0] units;
    cls_state_t       state;

    key_debouncer #(
        .DEBOUNCE(DEBOUNCE)
    ) u_key_debouncer (
        .Clk        (Clk),
        .Resetbar   (Resetbar),
        .Key_raw    (Key),
        .Key_db     (key_db),
        .Press_evt  (press_evt),
        .Release_evt(release_evt)
    );

    assign tick = (pres == PW'(TICK_DIV - 1));

    always_ff @(posedge Clk or negedge Resetbar) begin
        if (!Resetbar) begin
            state     <= IDLE;
            pres      <= '0;
            units     <= '0;
            Signals   <= SIG_NONE;
            Sig_Valid <= 1'b0;
        end else if (Clear) begin
            state     <= IDLE;
            pres      <= '0;
            units     <= '0;
            Signals   <= SIG_NONE;
            Sig_Valid <= 1'b0;
        end else begin
            Signals   <= SIG_NONE;
            Sig_Valid <= 1'b0;

            // Every debounced edge starts a fresh duration measurement.
            if (press_evt || release_evt) begin
                pres  <= '0;
                units <= '0;
            end else begin
                pres <= tick ? '0 : pres + 1'b1;
                if (tick && (units != '1))
                    units <= units + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (press_evt)
                        state <= PRESS;
                end
                PRESS: begin
                    if (release_evt) begin
                        Signals   <= (units >= CNT_W'(DASH_UNITS)) ? SIG_DASH : SIG_DOT;
                        Sig_Valid <= 1'b1;
                        state     <= GAP;
                    end
                end
                GAP: begin
                    // A press landing on the word-gap tick closes only the letter.
                    if (press_evt) begin
                        if (units >= CNT_W'(LETTER_GAP_UNITS)) begin
                            Signals   <= SIG_ENDSEQ;
                            Sig_Valid <= 1'b1;
                        end
                        state <= PRESS;
                    end else if (tick && (units == CNT_W'(WORD_GAP_UNITS - 1))) begin
                        Signals   <= SIG_SPACE;
                        Sig_Valid <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_morse_signal_classifier.sv
// Directed bench for morse_signal_classifier: stimulus queues expected codes with their cycle, a monitor checks them.
module tb_morse_signal_classifier;
    import morse_pkg::*;

    logic       Clk;
    logic       Resetbar;
    logic       Key;
    logic       Clear;
    logic [2:0] Signals;
    logic       Sig_Valid;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [2:0] code;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];

    morse_signal_classifier dut (
        .Clk      (Clk),
        .Resetbar (Resetbar),
        .Key      (Key),
        .Clear    (Clear),
        .Signals  (Signals),
        .Sig_Valid(Sig_Valid)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc <= cyc + 1;

    // A key change driven at a negedge with cycle count t surfaces as a code at cycle t+5.
    always @(negedge Clk) begin
        if (Resetbar) begin
            total++;
            if (Sig_Valid !== (Signals != SIG_NONE)) begin
                bad++;
                $display("FAIL valid_vs_code: cyc=%0d Sig_Valid=%b Signals=%b", cyc, Sig_Valid, Signals);
            end
            if (Sig_Valid === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_event: cyc=%0d got Signals=%b, expected no event", cyc, Signals);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (Signals !== e.code || cyc != e.cyc) begin
                        bad++;
                        $display("FAIL event: got code=%b at cyc=%0d, expected code=%b at cyc=%0d",
                                 Signals, cyc, e.code, e.cyc);
                    end
                end
            end
        end
    end

    task automatic push(input logic [2:0] code, input int at);
        exp_t e;
        e.code = code;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    // One key stroke: held for hi cycles, then released for lo cycles.
    task automatic stroke(input int hi, input int lo, input logic [2:0] pre,
                          input logic [2:0] rel, input bit space);
        int t;
        Key = 1'b1;
        t = cyc;
        if (pre != SIG_NONE) push(pre, t + 5);
        repeat (hi) @(negedge Clk);
        Key = 1'b0;
        t = cyc;
        if (rel != SIG_NONE) push(rel, t + 5);
        if (space) push(SIG_SPACE, t + 5 + 28);
        repeat (lo) @(negedge Clk);
    endtask

    task automatic glitch(input int lo);
        Key = 1'b1;
        @(negedge Clk);
        Key = 1'b0;
        repeat (lo) @(negedge Clk);
    endtask

    task automatic check_idle_out(input string name);
        total++;
        if (Signals !== SIG_NONE || Sig_Valid !== 1'b0) begin
            bad++;
            $display("FAIL %s: got Signals=%b Sig_Valid=%b, expected 111/0", name, Signals, Sig_Valid);
        end
    endtask

    initial begin
        int t;
        Key      = 1'b0;
        Clear    = 1'b0;
        Resetbar = 1'b1;
        #2 Resetbar = 1'b0;
        #1 check_idle_out("reset_state");
        repeat (3) @(negedge Clk);
        Resetbar = 1'b1;
        repeat (5) @(negedge Clk);

        glitch(10);                                  // idle glitch: nothing
        stroke(8,  16, SIG_NONE,   SIG_DOT,  1'b0);  // 8-cycle press: dot
        stroke(16,  4, SIG_ENDSEQ, SIG_DASH, 1'b0);  // 16-gap ends letter; 16-press dash
        stroke(12, 12, SIG_NONE,   SIG_DOT,  1'b0);  // 4-gap silent; 12-press dot
        stroke(13, 13, SIG_NONE,   SIG_DASH, 1'b0);  // 12-gap silent; 13-press dash
        stroke(8,  28, SIG_ENDSEQ, SIG_DOT,  1'b0);  // 13-gap ends letter
        stroke(8,  60, SIG_ENDSEQ, SIG_DOT,  1'b1);  // press on word tick wins; then space
        stroke(8,  10, SIG_NONE,   SIG_DOT,  1'b0);  // from idle: no end-of-letter
        glitch(5);                                   // mid-gap glitch, gap stays 16
        stroke(8,  40, SIG_ENDSEQ, SIG_DOT,  1'b1);

        // Clear mid-press drops the pending dash and the later space.
        Key = 1'b1;
        repeat (6) @(negedge Clk);
        Clear = 1'b1;
        @(negedge Clk);
        check_idle_out("clear_out");
        Clear = 1'b0;
        repeat (9) @(negedge Clk);
        Key = 1'b0;
        repeat (40) @(negedge Clk);
        stroke(8, 40, SIG_NONE, SIG_DOT, 1'b1);

        // Asynchronous reset during the dot pulse at the start of a gap.
        Key = 1'b1;
        repeat (8) @(negedge Clk);
        Key = 1'b0;
        t = cyc;
        push(SIG_DOT, t + 5);
        repeat (5) @(negedge Clk);
        #1 Resetbar = 1'b0;
        #1 check_idle_out("async_reset");
        repeat (3) @(negedge Clk);
        Resetbar = 1'b1;
        repeat (50) @(negedge Clk);
        stroke(8, 40, SIG_NONE, SIG_DOT, 1'b1);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_events: %0d expected events never appeared, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
